piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
Parallel-in, serial-out stage that sits directly upstream of the 1011 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per enabled clock on dout, which drives the detector's din. It supports gap-free back-to-back frames and a pacing enable, so test words and datapath words reach the detector as a contiguous bitstream.

Parameters:
WIDTH, 8, bits per frame; legal range is 2 to 32.
MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
clk  input  1  single clock; all state updates on posedge.
reset  input  1  asynchronous, active-high; clears all state immediately.
load_valid  input  1  upstream has a word on load_data.
load_ready  output  1  block can accept a word this cycle.
load_data  input  WIDTH  word to serialize; sampled only on handshake.
shift_en  input  1  pacing enable; tie to 1 for one bit per clock.
dout  output  1  current serial bit (feeds detector din).
dout_valid  output  1  dout carries a frame bit.
busy  output  1  a frame is in progress (state SHIFT).
frame_done  output  1  1-cycle pulse on the cycle the last bit of a frame is consumed.

Behaviour:
- States: IDLE and SHIFT. Internal registers: shift_reg[WIDTH-1:0], cnt (clog2(WIDTH) bits).
- Reset (async, while high) sets state=IDLE, shift_reg=0, cnt=0.
- Output values during and after reset: dout=0, dout_valid=0, busy=0, frame_done=0. load_ready is forced 0 while reset is high and is 1 in the first cycle after release.
- Handshake: a transfer occurs on a posedge where load_valid && load_ready.
  - load_data is captured only then.
  - load_valid with load_ready=0 is ignored; upstream holds its word.
- load_ready = (state==IDLE) || (state==SHIFT && shift_en && cnt==WIDTH-1). This is combinational from state, cnt and shift_en.
- Transfer in IDLE: shift_reg<=load_data, cnt<=0, state<=SHIFT. The first bit appears on dout the next cycle, so latency is 1 cycle.
- dout is driven combinationally from a register:
  - MSB_FIRST=1: dout = shift_reg[WIDTH-1].
  - MSB_FIRST=0: dout = shift_reg[0].
  - In IDLE, dout=0.
- dout_valid = busy = (state==SHIFT).
- SHIFT with shift_en=1 and cnt<WIDTH-1: shift toward the output end, filling with 0, and cnt<=cnt+1.
- SHIFT with shift_en=0: shift_reg, cnt and state hold, and dout holds its value. The bit counts as consumed only on a cycle where shift_en=1.
- SHIFT with shift_en=1 and cnt==WIDTH-1 (last bit): frame_done=1 this cycle.
  - With a transfer in the same cycle: reload shift_reg, cnt<=0, stay in SHIFT. There is no idle gap between frames.
  - Without a transfer: state<=IDLE and cnt<=0.
- frame_done = (state==SHIFT && shift_en && cnt==WIDTH-1). It is never high in IDLE.
- A frame emits exactly WIDTH consumed bits. The counter never wraps past WIDTH-1.
- Reset asserted mid-frame aborts the frame: outputs go to their reset values at once and no frame_done is produced.
- shift_en is ignored in IDLE.

Test Plan:
- Reset release, load_valid=0 -> load_ready=1; dout, dout_valid, busy and frame_done all 0 for 5 cycles.
- WIDTH=8, MSB_FIRST=1, load 8'hB0, shift_en=1 -> dout sequence 1,0,1,1,0,0,0,0 on cycles 1-8 after transfer; frame_done pulses on cycle 8; IDLE on cycle 9. The downstream detector fires on bit 4.
- Back-to-back 8'hB0 then 8'h0B with load_valid held -> 16 contiguous valid bits 10110000_00001011; second transfer on cycle 8; frame_done pulses on cycles 8 and 16; dout_valid never drops.
- MSB_FIRST=0, load 8'h0D -> dout 1,0,1,1,0,0,0,0 (LSB first).
- Load 8'hB0 with shift_en toggling 1,0,1,0,... -> each bit held 2 cycles; frame_done only on the enabled cycle of bit 8; load_ready=0 on the stalled last-bit cycle.
- Assert reset on bit 3 of 8'hFF -> dout=0 and busy=0 immediately; no frame_done; next load serializes cleanly from bit 0.

Source files
------------

// File: rtl/piso_bit_serializer_if.sv
`default_nettype none
// ============================================================================
// piso_bit_serializer_if : load handshake, pacing and serial output bundle
// Rev 1.0 - initial release
// ============================================================================
interface piso_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, dout, dout_valid, busy, frame_done
  );

  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, dout, dout_valid, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// piso_bit_serializer : WIDTH-bit parallel-in, serial-out stage with
//                       back-to-back frames and a pacing enable
// Rev 1.0 - initial release
// ============================================================================
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  piso_bit_serializer_if.slave  bus
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_out_bit;
  logic               w_last;
  logic               w_ready;
  logic               w_take;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
      assign w_out_bit = r_shift[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
      assign w_out_bit = r_shift[0];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_last      = (r_state == SHIFT) && bus.shift_en && (r_cnt == c_last);
    // Ready is held low during reset so upstream never sees a phantom accept.
    w_ready     = !reset && ((r_state == IDLE) || w_last);
    w_take      = bus.load_valid && w_ready;

    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_shift_nxt = bus.load_data;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (r_cnt != c_last) begin
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_cnt + 1'b1;
          end else if (w_take) begin
            w_shift_nxt = bus.load_data;
            w_cnt_nxt   = '0;
          end else begin
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.load_ready = w_ready;
  assign bus.dout       = (r_state == SHIFT) && w_out_bit;
  assign bus.dout_valid = (r_state == SHIFT);
  assign bus.busy       = (r_state == SHIFT);
  assign bus.frame_done = w_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// tb_piso_bit_serializer : scoreboard bench for MSB-first and LSB-first builds
// Rev 1.0 - initial release
// ============================================================================
module tb_piso_bit_serializer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  piso_bit_serializer_if #(.WIDTH(WIDTH)) ifa ();
  piso_bit_serializer_if #(.WIDTH(WIDTH)) ifb ();

  piso_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa)
  );

  piso_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Queues hold the bits of the frame still to be consumed, in output order.
  bit qa[$];
  bit qb[$];

  always @(negedge clk) begin
    bit eb, er, ed, ef;
    if (rst) begin
      qa.delete();
      check_eq("a_rst_ready", ifa.load_ready, 0);
      check_eq("a_rst_dout",  ifa.dout, 0);
      check_eq("a_rst_valid", ifa.dout_valid, 0);
      check_eq("a_rst_busy",  ifa.busy, 0);
      check_eq("a_rst_done",  ifa.frame_done, 0);
    end else begin
      eb = (qa.size() != 0);
      er = !eb || (ifa.shift_en && qa.size() == 1);
      ed = eb ? qa[0] : 1'b0;
      ef = eb && ifa.shift_en && qa.size() == 1;
      check_eq("a_ready", ifa.load_ready, er);
      check_eq("a_dout",  ifa.dout, ed);
      check_eq("a_valid", ifa.dout_valid, eb);
      check_eq("a_busy",  ifa.busy, eb);
      check_eq("a_done",  ifa.frame_done, ef);
      if (eb && ifa.shift_en) void'(qa.pop_front());
      if (ifa.load_valid && er)
        for (int i = WIDTH - 1; i >= 0; i--) qa.push_back(ifa.load_data[i]);
    end
  end

  always @(negedge clk) begin
    bit eb, er, ef;
    if (rst) begin
      qb.delete();
      check_eq("b_rst_ready", ifb.load_ready, 0);
      check_eq("b_rst_dout",  ifb.dout, 0);
    end else begin
      eb = (qb.size() != 0);
      er = !eb || (ifb.shift_en && qb.size() == 1);
      ef = eb && ifb.shift_en && qb.size() == 1;
      check_eq("b_ready", ifb.load_ready, er);
      check_eq("b_dout",  ifb.dout, eb ? qb[0] : 1'b0);
      check_eq("b_busy",  ifb.busy, eb);
      check_eq("b_done",  ifb.frame_done, ef);
      if (eb && ifb.shift_en) void'(qb.pop_front());
      if (ifb.load_valid && er)
        for (int i = 0; i < WIDTH; i++) qb.push_back(ifb.load_data[i]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [WIDTH-1:0] w);
    bit got = 0;
    ifa.load_valid = 1'b1;
    ifa.load_data  = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifa.load_ready) begin
        got = 1;
        break;
      end
    end
    tick(1);
    ifa.load_valid = 1'b0;
    if (!got) check_eq("a_send_timeout", 0, 1);
  endtask

  initial begin
    ifa.load_valid = 1'b0;
    ifa.load_data  = '0;
    ifa.shift_en   = 1'b1;
    ifb.load_valid = 1'b0;
    ifb.load_data  = '0;
    ifb.shift_en   = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);

    // single frame, then gap-free pair
    send_a(8'hB0);
    tick(12);
    send_a(8'hB0);
    send_a(8'h0B);
    tick(20);

    // LSB-first build
    ifb.load_valid = 1'b1;
    ifb.load_data  = 8'h0D;
    tick(1);
    ifb.load_valid = 1'b0;
    tick(12);

    // pacing enable toggling every cycle
    send_a(8'hB0);
    for (int i = 0; i < 24; i++) begin
      ifa.shift_en = ~ifa.shift_en;
      tick(1);
    end
    ifa.shift_en = 1'b1;
    tick(10);

    // abort mid-frame
    send_a(8'hFF);
    tick(2);
    rst = 1'b1;
    #1;
    check_eq("a_abort_busy", ifa.busy, 0);
    check_eq("a_abort_dout", ifa.dout, 0);
    check_eq("a_abort_done", ifa.frame_done, 0);
    tick(1);
    rst = 1'b0;
    send_a(8'hB0);
    tick(12);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      ifa.shift_en   = 1'($urandom_range(0, 1));
      ifa.load_valid = 1'($urandom_range(0, 1));
      ifa.load_data  = WIDTH'($urandom);
      tick(1);
    end
    ifa.load_valid = 1'b0;
    ifa.shift_en   = 1'b1;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
